// File: rtl/div_seq_pkg.sv
// Shared state encoding and handshake levels for the sequential divider.
// Used by div_seq, which optionally supports abort when DIV_ANNUL_EN is defined.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// The wide difference exposes the borrow directly; no borrow means quotient bit 1.
module div_seq_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   rem_in,
    input  logic              dvd_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W:0]   rem_out,
    output logic              q_bit
);

    logic [DATA_W+1:0] shifted;
    logic [DATA_W+1:0] diff;

    assign shifted = {rem_in, dvd_bit};
    assign diff    = shifted - {2'b00, divisor};
    assign q_bit   = ~diff[DATA_W+1];
    assign rem_out = q_bit ? diff[DATA_W:0] : shifted[DATA_W:0];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: returns {remainder, quotient} with ready_o.
// Define DIV_ANNUL_EN to add the annul_i abort input.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
`ifdef DIV_ANNUL_EN
    input  logic                  annul_i,
`endif
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    div_state_e          state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   dvd;
    logic [DATA_W-1:0]   dvs;
    logic [DATA_W:0]     rem;
    logic [DATA_W:0]     rem_step;
    logic                q_bit;
    logic                neg_q;
    logic                neg_r;
    logic                annul;

`ifdef DIV_ANNUL_EN
    assign annul = annul_i;
`else
    assign annul = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] neg_if(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
    endfunction

    div_seq_step #(.DATA_W(DATA_W)) u_step (
        .rem_in  (rem),
        .dvd_bit (dvd[DATA_W-1]),
        .divisor (dvs),
        .rem_out (rem_step),
        .q_bit   (q_bit)
    );

    always_comb begin
        state_next = state;
        case (state)
            DIV_FREE: begin
                if (start_i == DIV_START && !annul)
                    state_next = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
            end
            DIV_BY_ZERO: state_next = annul ? DIV_FREE : DIV_END;
            DIV_ON: begin
                if (annul)
                    state_next = DIV_FREE;
                else if (cnt == CNT_LAST)
                    state_next = DIV_END;
            end
            DIV_END: begin
                if (start_i != DIV_START)
                    state_next = DIV_FREE;
            end
            default: state_next = DIV_FREE;
        endcase
    end

    // Control: state, step counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
            result_o <= '0;
        end else begin
            state   <= state_next;
            ready_o <= (state_next == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
            if (state == DIV_FREE)
                cnt <= '0;
            else if (state == DIV_ON && cnt != CNT_LAST)
                cnt <= cnt + CNT_W'(1);
            if (state == DIV_ON && state_next == DIV_END)
                result_o <= {neg_if(neg_r, rem[DATA_W-1:0]), neg_if(neg_q, dvd)};
            else if (state_next != DIV_END)
                result_o <= '0;
        end
    end

    // Datapath: operand magnitudes latch while idle; dvd shifts quotient bits in from the LSB
    always_ff @(posedge clk) begin
        if (state == DIV_FREE) begin
            dvd   <= neg_if(signed_div_i & opdata1_i[DATA_W-1], opdata1_i);
            dvs   <= neg_if(signed_div_i & opdata2_i[DATA_W-1], opdata2_i);
            neg_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r <= signed_div_i & opdata1_i[DATA_W-1];
            rem   <= '0;
        end else if (state == DIV_ON && cnt != CNT_LAST) begin
            rem <= rem_step;
            dvd <= {dvd[DATA_W-2:0], q_bit};
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed-vector bench for div_seq: latency, signed/unsigned results, zero divisor, reset abort.
// Annul cases are compiled in when DIV_ANNUL_EN is defined.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_seq #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
`ifdef DIV_ANNUL_EN
        .annul_i      (annul),
`endif
        .result_o     (result),
        .ready_o      (ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input int exp_lat);
        int lat;
        lat = 0;
        @(negedge clk);
        signed_div = sgn;
        op1 = a;
        op2 = b;
        start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                op1 = $urandom;
                op2 = $urandom;
            end
            if (ready) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, result, {exp_r, exp_q});
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " ready drop"}, {63'd0, ready}, 64'd0);
        check({tag, " result clear"}, result, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        signed_div = 1'b0;
        op1 = '0;
        op2 = '0;
        start = 1'b0;
        annul = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", {63'd0, ready}, 64'd0);
        check("reset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("divu 100/7",       1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          34);
        run_op("div -7/2",         1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  34);
        run_op("div 7/-2",         1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          34);
        run_op("div -8/-3",        1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE,  34);
        run_op("divu big/2",       1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          34);
        run_op("divu x/0",         1'b0, 32'd1234,       32'd0,          32'd0,          32'd0,          2);
        run_op("div x/0",          1'b1, 32'hFFFF_FF00,  32'd0,          32'd0,          32'd0,          2);
        run_op("div min/-1",       1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          34);
        run_op("divu max/1",       1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          34);

        // Reset ten cycles into an operation discards it
        @(negedge clk);
        signed_div = 1'b0;
        op1 = 32'd100;
        op2 = 32'd7;
        start = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("midop rst ready", {63'd0, ready}, 64'd0);
        check("midop rst result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("post rst idle ready", {63'd0, ready}, 64'd0);
        run_op("after rst 1000/9", 1'b0, 32'd1000, 32'd9, 32'd111, 32'd1, 34);

`ifdef DIV_ANNUL_EN
        begin
            int seen;
            seen = 0;
            @(negedge clk);
            signed_div = 1'b0;
            op1 = 32'd100;
            op2 = 32'd7;
            start = 1'b1;
            repeat (5) @(posedge clk);
            @(negedge clk);
            annul = 1'b1;
            @(negedge clk);
            annul = 1'b0;
            start = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (ready) seen = 1;
            end
            check("annul ready never", 64'(seen), 64'd0);
            check("annul result", result, 64'd0);
        end
        run_op("annul restart", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
